// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU/HI-LO funct codes and the
// state encoding and step modes used by the multiply/divide unit.
package mips_pkg;

    // HI/LO funct codes
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MTHI  = 6'd17;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MTLO  = 6'd19;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;

    // ALU funct codes
    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_SLT = 6'd42;

    // hilo_muldiv FSM encoding
    typedef logic [1:0] md_state_t;
    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_MUL  = 2'd1;
    localparam md_state_t ST_DIV  = 2'd2;
    localparam md_state_t ST_DONE = 2'd3;

    localparam logic [4:0] LAST_ITER = 5'd31;

    // Iteration kind selected in muldiv_step
    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider,
// operating on the 64-bit accumulator {upper, lower}.
module muldiv_step
    import mips_pkg::*;
(
    input  logic        mode,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] next_acc
);

    logic [32:0] sum;
    logic [63:0] shifted;
    logic [32:0] rem;
    logic [31:0] diff;

    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        shifted  = {acc[62:0], 1'b0};
        // Keep the bit shifted out of the top so divisors above 2^31 still compare correctly.
        rem      = {acc[63], shifted[63:32]};
        diff     = rem[31:0] - operand;
        next_acc = {sum, acc[31:1]};

        if (mode == STEP_DIV) begin
            next_acc = shifted;
            if (rem >= {1'b0, operand}) begin
                next_acc[63:32] = diff;
                next_acc[0]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle unsigned MULTU/DIVU engine that owns the HI/LO pair;
// also services MTHI/MTLO in a single edge while idle.
module hilo_muldiv
    import mips_pkg::*;
#(
    parameter logic [5:0] MULTU = FUNCT_MULTU,
    parameter logic [5:0] DIVU  = FUNCT_DIVU,
    parameter logic [5:0] MTHI  = FUNCT_MTHI,
    parameter logic [5:0] MTLO  = FUNCT_MTLO
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic [63:0] hilo
);

    md_state_t   state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] operand;
    logic [63:0] next_acc;
    logic        step_mode;

    assign step_mode = (state == ST_DIV);
    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign done      = (state == ST_DONE);

    muldiv_step u_step (
        .mode     (step_mode),
        .acc      (acc),
        .operand  (operand),
        .next_acc (next_acc)
    );

    // operand holds the multiplicand for MULTU and the divisor for DIVU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            hilo    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (Signal == MULTU) begin
                            acc     <= {32'b0, dataB};
                            operand <= dataA;
                            count   <= '0;
                            state   <= ST_MUL;
                        end else if (Signal == DIVU) begin
                            acc     <= {32'b0, dataA};
                            operand <= dataB;
                            count   <= '0;
                            state   <= ST_DIV;
                        end else if (Signal == MTHI) begin
                            hilo[63:32] <= dataA;
                        end else if (Signal == MTLO) begin
                            hilo[31:0] <= dataA;
                        end
                    end
                end

                ST_MUL, ST_DIV: begin
                    acc   <= next_acc;
                    count <= count + 5'd1;
                    // The last step's result goes straight to HI/LO so they flip atomically.
                    if (count == LAST_ITER) begin
                        hilo  <= next_acc;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: vector table plus hand-written
// sequences, with a done-triggered scoreboard comparing hilo results.
module tb_hilo_muldiv;
    import mips_pkg::*;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [5:0]  Signal = 6'd0;
    logic [31:0] dataA  = 32'd0;
    logic [31:0] dataB  = 32'd0;
    logic        busy;
    logic        done;
    logic [63:0] hilo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    hilo_muldiv dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .Signal (Signal),
        .dataA  (dataA),
        .dataB  (dataB),
        .busy   (busy),
        .done   (done),
        .hilo   (hilo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (done) begin
            check("busy_low_at_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0)
                check("unexpected_done", {63'd0, done}, 64'd0);
            else
                check("hilo_result", hilo, sb.pop_front());
        end
    end

    // Drives one command for exactly one rising edge; returns at the following negedge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        Signal = op;
        dataA  = a;
        dataB  = b;
        @(negedge clk);
        start  = 1'b0;
        dataA  = $urandom;
        dataB  = $urandom;
    endtask

    task automatic wait_done(input string name, input logic [63:0] old, input int already);
        int lat = -1;
        for (int k = already + 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 31) begin
                check({name, "_hold"}, hilo, old);
                check({name, "_busy"}, {63'd0, busy}, 64'd1);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 40 cycles, expected at 32", name);
        end else begin
            check({name, "_latency"}, 64'(lat), 64'd32);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] old;
        old = hilo;
        sb.push_back(v.exp);
        issue(v.op, v.a, v.b);
        check({v.name, "_busy_start"}, {63'd0, busy}, 64'd1);
        wait_done(v.name, old, 0);
    endtask

    initial begin
        logic [63:0] old;

        vecs[0] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max"};
        vecs[1] = '{FUNCT_DIVU,  32'd100,      32'd7,        {32'd2, 32'd14},      "divu_100_7"};
        vecs[2] = '{FUNCT_DIVU,  32'd7,        32'd100,      {32'd7, 32'd0},       "divu_7_100"};
        vecs[3] = '{FUNCT_DIVU,  32'h1234,     32'd0,        {32'h1234, 32'hFFFFFFFF}, "divu_by_zero"};
        vecs[4] = '{FUNCT_MULTU, 32'hDEADBEEF, 32'd0,        64'd0,                "multu_zero"};
        vecs[5] = '{FUNCT_MULTU, 32'h00010000, 32'h00010000, 64'h00000001_00000000, "multu_carry"};
        vecs[6] = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'd1}, "divu_big_dvsr"};
        vecs[7] = '{FUNCT_DIVU,  32'd5,        32'd5,        {32'd0, 32'd1},       "divu_equal"};
        vecs[8] = '{FUNCT_MULTU, 32'd1234,     32'd5678,     64'd7006652,          "multu_1234"};

        repeat (2) @(negedge clk);
        check("reset_hilo", hilo, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i]);

        // MTHI / MTLO: single-edge update, no done pulse.
        issue(FUNCT_MTHI, 32'hDEADBEEF, 32'd0);
        check("mthi_hi", {32'd0, hilo[63:32]}, {32'd0, 32'hDEADBEEF});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        issue(FUNCT_MTLO, 32'h0BADF00D, 32'd0);
        check("mtlo_hilo", hilo, 64'hDEADBEEF_0BADF00D);
        check("mtlo_done", {63'd0, done}, 64'd0);

        // Non-HI/LO funct is ignored.
        old = hilo;
        issue(FUNCT_ADD, 32'h55555555, 32'hAAAAAAAA);
        check("ignore_add_busy", {63'd0, busy}, 64'd0);
        check("ignore_add_hilo", hilo, old);

        // MULTU 3x5 with an MTHI pulsed mid-computation.
        old = hilo;
        sb.push_back(64'd15);
        issue(FUNCT_MULTU, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        Signal = FUNCT_MTHI;
        dataA  = 32'h11111111;
        @(negedge clk);
        start  = 1'b0;
        check("mthi_while_busy_hilo", hilo, old);
        wait_done("multu_3_5", old, 4);

        // Asynchronous reset in the middle of an iteration.
        issue(FUNCT_MULTU, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", hilo, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle", {63'd0, busy}, 64'd0);
        run_vec(vecs[8]);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
